spi_ram: RTL and testbench
==========================

# spi_ram

Single-port synchronous RAM controller that sits directly downstream of the SPI slave. It consumes the slave's 10-bit received words (rx_data/rx_valid), decodes a 2-bit command, and maintains independent write and read address pointers with auto-increment. It returns read bytes to the slave on tx_data/tx_valid for shifting out on MISO.

## Interface
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE
- ADDR_SIZE, 8, address pointer width; legal range 1..8

- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- din  input  10  received word from the SPI slave; din[9:8] is the command, din[7:0] is the payload
- rx_valid  input  1  level from the SPI slave; high while din is complete; may stay high for many cycles
- dout  output  8  read data returned to the SPI slave (tx_data)
- tx_valid  output  1  dout holds a valid read result

## Operation
- Command event: a rising edge of rx_valid is detected with a registered copy rx_valid_q.
  - event = rx_valid & ~rx_valid_q, evaluated at each clk edge.
  - Exactly one command is executed per rx_valid assertion, however long rx_valid stays high.
  - din is sampled only at the event edge.
- Command decode on an event:
  - 2'b00 (set write address): wr_addr <= din[ADDR_SIZE-1:0].
  - 2'b01 (write data): mem[wr_addr] <= din[7:0]; wr_addr <= wr_addr + 1.
  - 2'b10 (set read address): rd_addr <= din[ADDR_SIZE-1:0].
  - 2'b11 (read data): dout <= mem[rd_addr]; tx_valid <= 1; rd_addr <= rd_addr + 1. din[7:0] is ignored.
- Pointer arithmetic:
  - Both pointers are ADDR_SIZE bits and increment modulo MEM_DEPTH (MEM_DEPTH-1 wraps to 0).
  - Payload bits above ADDR_SIZE are discarded.
- tx_valid clear rules, applied at the edge where the condition is sampled:
  - Clears to 0 on an event with any command other than 2'b11.
  - Clears to 0 when rx_valid falls (rx_valid_q=1, rx_valid=0), i.e. when the SPI transaction ends.
  - dout holds its last value after tx_valid clears.
- Back-to-back reads: a second 2'b11 event while tx_valid=1 keeps tx_valid=1 and loads the new byte into dout.
- Memory array:
  - Not reset.
  - Reading a location never written since power-up returns an undefined value.
  - Write-then-read of the same address on separate events returns the written byte.
- The block has no states beyond the pointer, output and edge-detect registers. Commands are fully decoded; no illegal encodings exist.

## Timing
- Reset (rst_n low, asynchronous):
  - dout=8'h00, tx_valid=0, wr_addr=0, rd_addr=0, rx_valid_q=0.
  - Memory contents are retained.
- Reset mid-operation: pointers and outputs clear immediately.
  - If rx_valid is high when rst_n releases, the first edge after release sees rx_valid_q=0 and executes din as a new event.
- Event latency:
  - rx_valid first sampled high at edge N → command executes at edge N.
  - For a read, dout and tx_valid are valid after edge N (one cycle after rx_valid rises).
- A write at edge N is visible to a read event at edge N+1 or later.
- Minimum event spacing is 2 cycles: rx_valid low for at least one sampled edge, then high again.
- Falling rx_valid sampled at edge M → tx_valid low after edge M.

## Test plan
- Reset check: assert rst_n low mid-stream → dout=00, tx_valid=0, and both pointers 0 asynchronously, without waiting for a clk edge.
- Basic write/read:
  - Sequence: event 00_0x3C, event 01_0xA5, event 10_0x3C, event 11_xx.
  - Required: dout=A5 and tx_valid=1 one cycle after the 11 event's rx_valid rise; tx_valid drops the cycle after rx_valid falls.
- Level rx_valid:
  - Hold rx_valid high for 20 cycles with din=01_0x11 after setting wr_addr=0x10.
  - Required: only mem[0x10]=11 is written; mem[0x11] is unchanged; wr_addr=0x11.
- Auto-increment and wrap:
  - Set wr_addr=0xFF, then write 0x01 and 0x02. Set rd_addr=0xFF, then issue two read events.
  - Required: dout=01, then 02 (address 0x00); rd_addr ends at 0x01.
- tx_valid clear on other command:
  - With tx_valid=1 after a read, issue an event with command 00.
  - Required: tx_valid=0 after that event edge; dout is unchanged.
- Back-to-back reads:
  - Two 11 events separated by one low cycle of rx_valid.
  - Required: dout updates to the second byte; tx_valid is 0 for the low cycle, then 1.

Source files
------------

// File: rtl/spi_ram.sv
// RAM controller behind the SPI slave: decodes 10-bit received words into
// address-set / write / read commands and returns read bytes for MISO.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  logic [7:0]           mem [MEM_DEPTH];

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_we;
  logic                 cmd_event;
  logic                 rx_fall;

  // rx_valid is a level, so a command fires only on its rising edge
  assign cmd_event = rx_valid & ~rx_valid_q;
  assign rx_fall   = ~rx_valid & rx_valid_q;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    mem_we     = 1'b0;
    if (cmd_event) begin
      tx_valid_d = 1'b0;
      case (din[9:8])
        2'b00: wr_addr_d = din[ADDR_SIZE-1:0];
        2'b01: begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
        end
        2'b10: rd_addr_d = din[ADDR_SIZE-1:0];
        default: begin
          dout_d     = mem[rd_addr_q];
          tx_valid_d = 1'b1;
          rd_addr_d  = rd_addr_q + 1'b1;
        end
      endcase
    end else if (rx_fall) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Array has no reset so its contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= din[7:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a behavioural memory model pushes expected
// read bytes into a queue, popped when the DUT presents tx_valid.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxValid = 1'b0;
  logic [9:0] din = 10'h000;
  logic [7:0] dout;
  logic       txValid;

  int checks = 0;
  int failures = 0;

  logic [7:0] model [0:255];
  logic [7:0] modelWr = 8'h00;
  logic [7:0] modelRd = 8'h00;
  logic [7:0] expQ [$];
  logic [7:0] lastDout = 8'h00;

  always #5 clk = ~clk;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rxValid),
    .dout     (dout),
    .tx_valid (txValid)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise rx_valid with a command, update the model, hold for 'hold' edges
  task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] payload, input int hold);
    din     = {cmd, payload};
    rxValid = 1'b1;
    case (cmd)
      2'b00: modelWr = payload;
      2'b01: begin
        model[modelWr] = payload;
        modelWr = modelWr + 8'd1;
      end
      2'b10: modelRd = payload;
      default: begin
        expQ.push_back(model[modelRd]);
        modelRd = modelRd + 8'd1;
      end
    endcase
    repeat (hold) @(negedge clk);
  endtask

  task automatic releaseRx();
    rxValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkRead(input string tag);
    logic [7:0] exp;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=queue-empty expected=entry", tag);
    end else begin
      exp = expQ.pop_front();
      checkOutput({tag, "_dout"}, dout, exp);
      checkOutput({tag, "_txv"}, {7'b0, txValid}, 8'h01);
      lastDout = exp;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    checkOutput("rst_dout", dout, 8'h00);
    checkOutput("rst_txv", {7'b0, txValid}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read
    applyStimulus(2'b00, 8'h3C, 1); releaseRx();
    applyStimulus(2'b01, 8'hA5, 1); releaseRx();
    applyStimulus(2'b10, 8'h3C, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1);
    checkRead("basic");
    releaseRx();
    checkOutput("basic_fall_txv", {7'b0, txValid}, 8'h00);
    checkOutput("basic_fall_dout", dout, lastDout);

    // Level rx_valid: one write despite 20 high cycles
    applyStimulus(2'b00, 8'h11, 1); releaseRx();
    applyStimulus(2'b01, 8'h77, 1); releaseRx();
    applyStimulus(2'b00, 8'h10, 1); releaseRx();
    applyStimulus(2'b01, 8'h11, 20); releaseRx();
    applyStimulus(2'b10, 8'h10, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("level_0x10"); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("level_0x11"); releaseRx();
    applyStimulus(2'b01, 8'h99, 1); releaseRx();
    applyStimulus(2'b10, 8'h11, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("level_wrptr"); releaseRx();

    // Auto-increment and wrap
    applyStimulus(2'b00, 8'hFF, 1); releaseRx();
    applyStimulus(2'b01, 8'h01, 1); releaseRx();
    applyStimulus(2'b01, 8'h02, 1); releaseRx();
    applyStimulus(2'b01, 8'h33, 1); releaseRx();
    applyStimulus(2'b10, 8'hFF, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("wrap_ff"); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("wrap_00"); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("wrap_01"); releaseRx();

    // tx_valid clear on a non-read command, dout held
    applyStimulus(2'b10, 8'h3C, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("clr_read"); releaseRx();
    applyStimulus(2'b00, 8'h40, 1);
    checkOutput("clr_txv", {7'b0, txValid}, 8'h00);
    checkOutput("clr_dout", dout, lastDout);
    releaseRx();

    // Back-to-back reads with one low cycle between
    applyStimulus(2'b10, 8'h10, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("b2b_first");
    releaseRx();
    checkOutput("b2b_gap_txv", {7'b0, txValid}, 8'h00);
    applyStimulus(2'b11, 8'h00, 1); checkRead("b2b_second");
    releaseRx();

    // Asynchronous reset mid-read, then release with rx_valid still high
    applyStimulus(2'b10, 8'h3C, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dout", dout, 8'h00);
    checkOutput("async_rst_txv", {7'b0, txValid}, 8'h00);
    @(negedge clk);
    modelWr = 8'h00;
    modelRd = 8'h00;
    rst_n = 1'b1;
    applyStimulus(2'b11, 8'h00, 1); checkRead("post_rst_rdptr"); releaseRx();
    applyStimulus(2'b01, 8'hC3, 1); releaseRx();
    applyStimulus(2'b10, 8'h00, 1); releaseRx();
    applyStimulus(2'b11, 8'h00, 1); checkRead("post_rst_wrptr"); releaseRx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
